stopwatch_datapath: RTL and testbench

- Time-base and control block directly upstream of the FND display controller.
- Generates a 100 Hz centisecond tick from the system clock and runs a stopwatch counter chain: msec (centiseconds) 0–99, sec 0–59, min 0–59, hour 0–23.
- Driven by pre-debounced single-cycle button pulses.
- Its msec/sec/min/hour outputs feed the display controller's inputs of the same names and widths.

---
 rtl/stopwatch_datapath.sv | 100 ++++++++++
 tb/tb_stopwatch_datapath.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_datapath.sv
// stopwatch_datapath: centisecond time base and run/stop/clear stopwatch chain (hh:mm:ss.cc).
// Define STOPWATCH_LAP_HOLD_EN to add the i_lap output-freeze (lap hold) feature.
module stopwatch_datapath #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_run_stop,
  input  logic       i_clear,
  input  logic       i_lap,
  output logic [6:0] msec,
  output logic [6:0] sec,
  output logic [6:0] min,
  output logic [4:0] hour,
  output logic       o_running
);
  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int TW  = $clog2(DIV);
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  state_t state, state_next;
  logic [TW-1:0] cnt;
  logic [6:0] ms, s, m;
  logic [4:0] h;
  logic tick;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = i_run_stop ? RUN : IDLE;
      RUN:     state_next = i_run_stop ? STOP : RUN;
      STOP:    state_next = i_clear ? IDLE : i_run_stop ? RUN : STOP;
      default: state_next = IDLE;
    endcase
  end
  assign tick = (state == RUN) && (cnt == TW'(DIV - 1));
  // IDLE always holds a zeroed time base, so entry to IDLE and staying there both clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      o_running <= 1'b0;
      cnt       <= '0;
      ms        <= '0;
      s         <= '0;
      m         <= '0;
      h         <= '0;
    end else begin
      state     <= state_next;
      o_running <= state_next == RUN;
      if (state_next == IDLE) begin
        cnt <= '0;
        ms  <= '0;
        s   <= '0;
        m   <= '0;
        h   <= '0;
      end else if (state == RUN) begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (tick) begin
          ms <= (ms == 7'd99) ? '0 : ms + 7'd1;
          if (ms == 7'd99) begin
            s <= (s == 7'd59) ? '0 : s + 7'd1;
            if (s == 7'd59) begin
              m <= (m == 7'd59) ? '0 : m + 7'd1;
              if (m == 7'd59) h <= (h == 5'd23) ? '0 : h + 5'd1;
            end
          end
        end
      end
    end
  end
`ifdef STOPWATCH_LAP_HOLD_EN
  logic hold;
  logic [6:0] ms_snap, s_snap, m_snap;
  logic [4:0] h_snap;
  // snapshot captures the value displayed when the lap is pressed; the live chain keeps counting
  always_ff @(posedge clk) begin
    if (!reset || state_next == IDLE) begin
      hold <= 1'b0;
    end else if (i_lap && state == RUN) begin
      hold <= !hold;
      if (!hold) begin
        ms_snap <= ms;
        s_snap  <= s;
        m_snap  <= m;
        h_snap  <= h;
      end
    end
  end
  assign msec = hold ? ms_snap : ms;
  assign sec  = hold ? s_snap : s;
  assign min  = hold ? m_snap : m;
  assign hour = hold ? h_snap : h;
`else
  logic unused_lap;
  assign unused_lap = i_lap;
  assign msec = ms;
  assign sec  = s;
  assign min  = m;
  assign hour = h;
`endif
endmodule

// File: tb/tb_stopwatch_datapath.sv
// tb_stopwatch_datapath: directed vector table, corner sequences and random run of stopwatch_datapath (DIV=10).
module tb_stopwatch_datapath;
  localparam int DIV = 10;
  localparam int DAY = 24 * 60 * 60 * 100;
`ifdef STOPWATCH_LAP_HOLD_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif
  logic clk, reset, i_run_stop, i_clear, i_lap;
  logic [6:0] msec, sec, min;
  logic [4:0] hour;
  logic o_running;
  int vectors = 0;
  int miscompares = 0;
  // reference model: mode 0=idle 1=run 2=stop, elapsed time as total centiseconds
  int mode, total, phase, snap;
  bit hold;

  stopwatch_datapath #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
    .clk(clk), .reset(reset), .i_run_stop(i_run_stop), .i_clear(i_clear), .i_lap(i_lap),
    .msec(msec), .sec(sec), .min(min), .hour(hour), .o_running(o_running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_step(input bit r, input bit rs, input bit clr, input bit lap);
    int nm;
    if (!r) begin
      mode = 0; total = 0; phase = 0; hold = 0;
      return;
    end
    nm = mode;
    if (mode == 0 && rs) nm = 1;
    else if (mode == 1 && rs) nm = 2;
    else if (mode == 2) nm = clr ? 0 : (rs ? 1 : 2);
    if (LAP_EN && lap && mode == 1) begin
      if (!hold) snap = total;
      hold = !hold;
    end
    if (mode == 1) begin
      phase = phase + 1;
      if (phase == DIV) begin
        phase = 0;
        total = (total + 1) % DAY;
      end
    end
    mode = nm;
    if (mode == 0) begin
      total = 0; phase = 0; hold = 0;
    end
  endtask

  task automatic check_model();
    int t;
    logic [26:0] got, want;
    t = hold ? snap : total;
    got = {msec, sec, min, hour, o_running};
    want = {7'(t % 100), 7'((t / 100) % 60), 7'((t / 6000) % 60), 5'((t / 360000) % 24), mode == 1};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL model t=%0t: got %0d:%0d:%0d.%0d run=%0b, want %0d:%0d:%0d.%0d run=%0b", $time,
               hour, min, sec, msec, o_running, want[5:1], want[12:6], want[19:13], want[26:20], want[0]);
    end
  endtask

  task automatic check_const(input string name, input int h, input int m, input int s, input int ms, input bit run);
    vectors++;
    if (hour !== 5'(h) || min !== 7'(m) || sec !== 7'(s) || msec !== 7'(ms) || o_running !== run) begin
      miscompares++;
      $display("FAIL %s: got %0d:%0d:%0d.%0d run=%0b, want %0d:%0d:%0d.%0d run=%0b",
               name, hour, min, sec, msec, o_running, h, m, s, ms, run);
    end
  endtask

  task automatic step(input bit r, input bit rs, input bit clr, input bit lap);
    reset = r; i_run_stop = rs; i_clear = clr; i_lap = lap;
    @(posedge clk);
    model_step(r, rs, clr, lap);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0);
  endtask

  typedef struct {
    bit r, rs, clr;
    int n, ms, s;
    bit run;
  } vec_t;
  vec_t tbl[19];

  initial begin
    tbl[0]  = '{0, 0, 0, 3,    0,  0, 0};
    tbl[1]  = '{1, 0, 0, 1,    0,  0, 0};
    tbl[2]  = '{1, 1, 0, 1,    0,  0, 1};
    tbl[3]  = '{1, 0, 0, 10,   1,  0, 1};
    tbl[4]  = '{1, 0, 0, 40,   5,  0, 1};
    tbl[5]  = '{1, 0, 0, 35,   8,  0, 1};
    tbl[6]  = '{1, 1, 0, 1,    8,  0, 0};
    tbl[7]  = '{1, 0, 0, 100,  8,  0, 0};
    tbl[8]  = '{1, 1, 0, 1,    8,  0, 1};
    tbl[9]  = '{1, 0, 0, 3,    8,  0, 1};
    tbl[10] = '{1, 0, 0, 1,    9,  0, 1};
    tbl[11] = '{1, 0, 1, 1,    9,  0, 1};
    tbl[12] = '{1, 0, 0, 9,    10, 0, 1};
    tbl[13] = '{1, 1, 0, 1,    10, 0, 0};
    tbl[14] = '{1, 1, 1, 1,    0,  0, 0};
    tbl[15] = '{1, 0, 0, 5,    0,  0, 0};
    tbl[16] = '{1, 0, 1, 1,    0,  0, 0};
    tbl[17] = '{1, 1, 0, 1,    0,  0, 1};
    tbl[18] = '{1, 0, 0, 1000, 0,  1, 1};
    mode = 0; total = 0; phase = 0; snap = 0; hold = 0;
    reset = 1'b0; i_run_stop = 1'b0; i_clear = 1'b0; i_lap = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].r, tbl[i].rs, tbl[i].clr, 1'b0);
      for (int k = 1; k < tbl[i].n; k++) step(tbl[i].r, 0, 0, 0);
      check_const($sformatf("vec%0d", i), 0, 0, tbl[i].s, tbl[i].ms, tbl[i].run);
    end
    // reset on the very cycle a tick is due, with buttons also pressed
    idle(1009);
    check_const("pre_reset", 0, 0, 2, 0, 1);
    step(0, 1, 1, 1);
    check_const("reset_mid_tick", 0, 0, 0, 0, 0);
    step(1, 0, 0, 0);
    check_const("after_reset", 0, 0, 0, 0, 0);
    // preload 23:59:59.99 one cycle before a tick, then let the full day wrap happen
    step(1, 1, 0, 0);
    idle(9);
    force dut.ms = 7'd99;
    force dut.s = 7'd59;
    force dut.m = 7'd59;
    force dut.h = 5'd23;
    #1;
    release dut.ms;
    release dut.s;
    release dut.m;
    release dut.h;
    total = DAY - 1;
    check_const("preload", 23, 59, 59, 99, 1);
    step(1, 0, 0, 0);
    check_const("day_wrap", 0, 0, 0, 0, 1);
    idle(10);
    check_const("after_wrap", 0, 0, 0, 1, 1);
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    check_const("clear_stop", 0, 0, 0, 0, 0);
`ifdef STOPWATCH_LAP_HOLD_EN
    step(1, 1, 0, 0);
    idle(200);
    check_const("lap_pre", 0, 0, 0, 20, 1);
    step(1, 0, 0, 1);
    check_const("lap_set", 0, 0, 0, 20, 1);
    idle(300);
    check_const("lap_frozen", 0, 0, 0, 20, 1);
    step(1, 0, 0, 1);
    check_const("lap_release", 0, 0, 0, 50, 1);
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
`endif
    for (int i = 0; i < 5000; i++)
      step($urandom_range(199) != 0, $urandom_range(29) == 0, $urandom_range(29) == 0, $urandom_range(24) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
